io_bus_ctrl: RTL and testbench

- Parametrised memory-mapped I/O controller between the multicycle CPU bus (adr / writedata / memwrite / memread) and the game peripherals.
- Decodes each address into program, data or I/O space and drives the memory enable for the exmem block.
- Holds the per-player display registers and an LFSR random register.
- Runs a round-arbitration FSM that captures which player buzzed in first.

---
 rtl/io_bus_pkg.sv | 26 ++
 rtl/first_arbiter.sv | 20 ++
 rtl/io_bus_ctrl.sv | 219 +++++++++++++++++++++
 tb/tb_io_bus_ctrl.sv | 292 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/io_bus_pkg.sv
// Shared encodings for the I/O bus controller: address spaces, round FSM states,
// I/O register word offsets and the random-number LFSR step.
package io_bus_pkg;

    localparam logic [1:0] SPACE_PROG = 2'd0;
    localparam logic [1:0] SPACE_DATA = 2'd1;
    localparam logic [1:0] SPACE_IO   = 2'd2;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ARMED  = 2'd1,
        ST_LOCKED = 2'd2
    } state_e;

    localparam int OFF_STATUS = 32'd0;
    localparam int OFF_FIRST  = 32'd1;
    localparam int OFF_RAND   = 32'd2;
    localparam int OFF_CTRL   = 32'd3;
    localparam int OFF_P0     = 32'd4;

    // Fibonacci form, taps 16,14,13,11 seen from the shift-right side
    function automatic logic [15:0] lfsr_next(input logic [15:0] cur);
        return {cur[0] ^ cur[2] ^ cur[3] ^ cur[5], cur[15:1]};
    endfunction

endpackage

// File: rtl/first_arbiter.sv
// Lowest-index priority encoder used to pick the player who buzzed first.
module first_arbiter #(
    parameter int N = 4
) (
    input  logic [N-1:0] i_valid,
    output logic         o_any,
    output logic [2:0]   o_idx
);

    assign o_any = |i_valid;

    // Scan downwards so the lowest asserted index is the last one written
    always_comb begin
        o_idx = 3'd0;
        for (int i = N - 1; i >= 0; i--) begin
            o_idx = i_valid[i] ? 3'(i) : o_idx;
        end
    end

endmodule

// File: rtl/io_bus_ctrl.sv
// Memory-mapped I/O controller: address decode, player display registers, LFSR and
// buzz-in round arbitration. Define IO_BUS_IRQ_EN to add the registered irq output.
module io_bus_ctrl
    import io_bus_pkg::*;
#(
    parameter int                ADDR_W      = 16,
    parameter int                DATA_W      = 16,
    parameter int                NUM_PLAYERS = 4,
    parameter int                PIN_W       = 4,
    parameter logic [ADDR_W-1:0] PROG_TOP    = 16'hA000,
    parameter logic [ADDR_W-1:0] IO_BASE     = 16'hC000,
    parameter logic [15:0]       LFSR_SEED   = 16'hACE1
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic [ADDR_W-1:0]             adr,
    input  logic [DATA_W-1:0]             writedata,
    input  logic                          memwrite,
    input  logic                          memread,
    input  logic [NUM_PLAYERS-1:0]        player_valid,
    input  logic [NUM_PLAYERS*PIN_W-1:0]  player_code,
    output logic                          mem_en,
    output logic [1:0]                    space,
    output logic [DATA_W-1:0]             readdata,
    output logic                          readvalid,
    output logic [NUM_PLAYERS*DATA_W-1:0] p_regs,
`ifdef IO_BUS_IRQ_EN
    output logic                          irq,
`endif
    output logic [DATA_W-1:0]             rand_val
);

    logic                          w_is_io;
    logic [ADDR_W-1:0]             w_off;
    logic                          w_wr_io;
    logic                          w_rd_io;
    logic                          w_status_wr;
    logic                          w_arm;
    logic                          w_any;
    logic [2:0]                    w_idx;
    logic                          w_irq_stat;
    logic [DATA_W-1:0]             w_p_rd;
    logic [DATA_W-1:0]             w_rdata;

    state_e                        r_state;
    state_e                        w_state_n;
    logic [NUM_PLAYERS-1:0]        r_flags;
    logic [NUM_PLAYERS-1:0]        w_flags_n;
    logic [2:0]                    r_first_id;
    logic [2:0]                    w_first_id_n;
    logic [PIN_W-1:0]              r_first_code;
    logic [PIN_W-1:0]              w_first_code_n;
    logic [15:0]                   r_lfsr;
    logic [NUM_PLAYERS*DATA_W-1:0] r_p_regs;
    logic [DATA_W-1:0]             r_readdata;
    logic                          r_readvalid;

    assign w_is_io     = (adr >= IO_BASE);
    assign w_off       = adr - IO_BASE;
    assign w_wr_io     = memwrite & w_is_io;
    assign w_rd_io     = memread & ~memwrite & w_is_io;
    assign w_status_wr = w_wr_io && (w_off == ADDR_W'(OFF_STATUS));
    assign w_arm       = w_wr_io && (w_off == ADDR_W'(OFF_CTRL)) && writedata[0];

    assign mem_en    = ~w_is_io;
    assign readdata  = r_readdata;
    assign readvalid = r_readvalid;
    assign p_regs    = r_p_regs;
    assign rand_val  = DATA_W'(r_lfsr);

    // Address-space classification for the exmem side
    always_comb begin
        if (adr < PROG_TOP) begin
            space = SPACE_PROG;
        end else if (!w_is_io) begin
            space = SPACE_DATA;
        end else begin
            space = SPACE_IO;
        end
    end

    first_arbiter #(
        .N(NUM_PLAYERS)
    ) u_first_arbiter (
        .i_valid(player_valid),
        .o_any  (w_any),
        .o_idx  (w_idx)
    );

    // Round FSM next state; a STATUS write beats an arm, and an arm swallows same-cycle buzzes
    always_comb begin
        w_state_n      = r_state;
        w_flags_n      = r_flags;
        w_first_id_n   = r_first_id;
        w_first_code_n = r_first_code;
        if (w_status_wr) begin
            w_state_n = ST_IDLE;
            w_flags_n = '0;
        end else if (w_arm) begin
            w_state_n      = ST_ARMED;
            w_flags_n      = '0;
            w_first_id_n   = 3'd0;
            w_first_code_n = '0;
        end else begin
            case (r_state)
                ST_ARMED: begin
                    w_flags_n = r_flags | player_valid;
                    if (w_any) begin
                        w_state_n      = ST_LOCKED;
                        w_first_id_n   = w_idx;
                        w_first_code_n = player_code[w_idx*PIN_W +: PIN_W];
                    end else begin
                        w_state_n = ST_ARMED;
                    end
                end
                ST_LOCKED: w_flags_n = r_flags | player_valid;
                default:   w_state_n = r_state;
            endcase
        end
    end

    // FSM state register
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_n;
        end
    end

    // Round capture registers, player registers and the free-running LFSR
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_flags      <= '0;
            r_first_id   <= 3'd0;
            r_first_code <= '0;
            r_lfsr       <= LFSR_SEED;
            r_p_regs     <= '0;
        end else begin
            r_flags      <= w_flags_n;
            r_first_id   <= w_first_id_n;
            r_first_code <= w_first_code_n;
            r_lfsr       <= lfsr_next(r_lfsr);
            for (int i = 0; i < NUM_PLAYERS; i++) begin
                if (w_wr_io && (w_off == ADDR_W'(OFF_P0 + i))) begin
                    r_p_regs[i*DATA_W +: DATA_W] <= writedata;
                end
            end
        end
    end

`ifdef IO_BUS_IRQ_EN
    logic r_irq;
    logic w_irq_n;

    assign irq        = r_irq;
    assign w_irq_stat = r_irq;

    // irq rises on the ARMED->LOCKED capture and only a STATUS write drops it
    always_comb begin
        if (w_status_wr) begin
            w_irq_n = 1'b0;
        end else if (!w_arm && (r_state == ST_ARMED) && w_any) begin
            w_irq_n = 1'b1;
        end else begin
            w_irq_n = r_irq;
        end
    end

    // irq register
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_irq <= 1'b0;
        end else begin
            r_irq <= w_irq_n;
        end
    end
`else
    assign w_irq_stat = 1'b0;
`endif

    // Player register read-back; unmatched offsets fall through as zero
    always_comb begin
        w_p_rd = '0;
        for (int i = 0; i < NUM_PLAYERS; i++) begin
            w_p_rd = (w_off == ADDR_W'(OFF_P0 + i)) ? r_p_regs[i*DATA_W +: DATA_W] : w_p_rd;
        end
    end

    // I/O read mux
    always_comb begin
        w_rdata = '0;
        case (w_off)
            ADDR_W'(OFF_STATUS): begin
                w_rdata[NUM_PLAYERS-1:0] = r_flags;
                w_rdata[13:12]           = r_state;
                w_rdata[14]              = w_irq_stat;
                w_rdata[15]              = (r_state == ST_LOCKED);
            end
            ADDR_W'(OFF_FIRST): w_rdata = DATA_W'({r_first_code, 1'b0, r_first_id});
            ADDR_W'(OFF_RAND):  w_rdata = DATA_W'(r_lfsr);
            default:            w_rdata = w_p_rd;
        endcase
    end

    // Registered read port: one-cycle latency, write-only cycles give no pulse
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_readdata  <= '0;
            r_readvalid <= 1'b0;
        end else if (w_rd_io) begin
            r_readdata  <= w_rdata;
            r_readvalid <= 1'b1;
        end else begin
            r_readvalid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_io_bus_ctrl.sv
// Self-checking bench for io_bus_ctrl: directed steps plus a randomized phase
// checked against a cycle-level behavioural model of the register map and round rules.
module tb_io_bus_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic [15:0] adr;
    logic [15:0] writedata;
    logic        memwrite;
    logic        memread;
    logic [3:0]  player_valid;
    logic [15:0] player_code;
    logic        mem_en;
    logic [1:0]  space;
    logic [15:0] readdata;
    logic        readvalid;
    logic [63:0] p_regs;
    logic [15:0] rand_val;
`ifdef IO_BUS_IRQ_EN
    logic        irq;
    localparam bit IRQ_ON = 1'b1;
`else
    localparam bit IRQ_ON = 1'b0;
`endif

    int total = 0;
    int bad   = 0;

    // behavioural model state
    int          m_state;
    logic [3:0]  m_flags;
    logic [2:0]  m_id;
    logic [3:0]  m_code;
    logic [15:0] m_p [4];
    logic [15:0] m_lfsr;
    logic        m_irq;
    logic [15:0] m_rd;
    logic        m_rv;

    logic [15:0] first_rand;

    io_bus_ctrl dut (
        .clk         (clk),
        .rst         (rst),
        .adr         (adr),
        .writedata   (writedata),
        .memwrite    (memwrite),
        .memread     (memread),
        .player_valid(player_valid),
        .player_code (player_code),
        .mem_en      (mem_en),
        .space       (space),
        .readdata    (readdata),
        .readvalid   (readvalid),
        .p_regs      (p_regs),
`ifdef IO_BUS_IRQ_EN
        .irq         (irq),
`endif
        .rand_val    (rand_val)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic logic [15:0] lfsr_step(input logic [15:0] x);
        return {x[0] ^ x[2] ^ x[3] ^ x[5], x[15:1]};
    endfunction

    function automatic logic [1:0] exp_space(input logic [15:0] a);
        if (a < 16'hA000) return 2'd0;
        if (a < 16'hC000) return 2'd1;
        return 2'd2;
    endfunction

    function automatic logic [15:0] read_model(input logic [15:0] off);
        logic [15:0] v;
        v = 16'h0000;
        if (off == 16'd0)      v = {m_state == 2, IRQ_ON & m_irq, 2'(m_state), 8'h00, m_flags};
        else if (off == 16'd1) v = {8'h00, m_code, 1'b0, m_id};
        else if (off == 16'd2) v = m_lfsr;
        else if (off >= 16'd4 && off <= 16'd7) v = m_p[off - 16'd4];
        return v;
    endfunction

    task automatic model_reset();
        m_state = 0;
        m_flags = 4'h0;
        m_id    = 3'd0;
        m_code  = 4'h0;
        for (int i = 0; i < 4; i++) m_p[i] = 16'h0000;
        m_lfsr  = 16'hACE1;
        m_irq   = 1'b0;
        m_rv    = 1'b0;
        m_rd    = 16'h0000;
    endtask

    // one clock: check decode, advance the model from current inputs, check outputs after the edge
    task automatic tick();
        logic        io;
        logic        wr;
        logic        rd;
        logic [15:0] off;
        #1;
        check("space", 64'(space), 64'(exp_space(adr)));
        check("mem_en", 64'(mem_en), 64'(adr < 16'hC000));
        io  = (adr >= 16'hC000);
        off = adr - 16'hC000;
        wr  = memwrite && io;
        rd  = memread && !memwrite && io;
        m_rv = rd;
        if (rd) m_rd = read_model(off);
        if (wr && off >= 16'd4 && off <= 16'd7) m_p[off - 16'd4] = writedata;
        if (wr && off == 16'd0) begin
            m_state = 0; m_flags = 4'h0; m_irq = 1'b0;
        end else if (wr && off == 16'd3 && writedata[0]) begin
            m_state = 1; m_flags = 4'h0; m_id = 3'd0; m_code = 4'h0;
        end else if (m_state != 0) begin
            m_flags |= player_valid;
            if (m_state == 1 && player_valid != 4'h0) begin
                for (int i = 3; i >= 0; i--) begin
                    if (player_valid[i]) begin
                        m_id   = 3'(i);
                        m_code = player_code[i*4 +: 4];
                    end
                end
                m_state = 2;
                m_irq   = 1'b1;
            end
        end
        m_lfsr = lfsr_step(m_lfsr);
        @(posedge clk);
        #1;
        check("readvalid", 64'(readvalid), 64'(m_rv));
        if (m_rv) check("readdata", 64'(readdata), 64'(m_rd));
        check("rand_val", 64'(rand_val), 64'(m_lfsr));
        check("p_regs", p_regs, {m_p[3], m_p[2], m_p[1], m_p[0]});
`ifdef IO_BUS_IRQ_EN
        check("irq", 64'(irq), 64'(m_irq));
`endif
    endtask

    task automatic bus_wr(input logic [15:0] a, input logic [15:0] d);
        adr = a; writedata = d; memwrite = 1'b1; memread = 1'b0;
        tick();
        memwrite = 1'b0;
    endtask

    task automatic bus_rd(input logic [15:0] a);
        adr = a; memread = 1'b1; memwrite = 1'b0;
        tick();
        memread = 1'b0;
    endtask

    logic [15:0] sweep_adr [4] = '{16'h9FFF, 16'hA000, 16'hBFFF, 16'hC000};
    logic [1:0]  sweep_sp  [4] = '{2'd0, 2'd1, 2'd1, 2'd2};
    logic        sweep_en  [4] = '{1'b1, 1'b1, 1'b1, 1'b0};

    initial begin
        rst = 1'b0; adr = 16'h0000; writedata = 16'h0000; memwrite = 1'b0; memread = 1'b0;
        player_valid = 4'h0; player_code = 16'h0000;
        model_reset();
        @(posedge clk); @(posedge clk); #2;
        check("rst_readdata", 64'(readdata), 64'h0);
        check("rst_readvalid", 64'(readvalid), 64'h0);
        check("rst_p_regs", p_regs, 64'h0);
        check("rst_rand", 64'(rand_val), 64'hACE1);
        @(negedge clk);
        rst = 1'b1;

        // LFSR read-back
        tick();
        adr = 16'hC002; memread = 1'b1;
        tick();
        first_rand = readdata;
        check("rand_first", 64'(readdata), 64'h5670);
        tick();
        check("rand_differ", 64'(readdata != first_rand), 64'h1);
        memread = 1'b0;
        tick();

        // address boundaries
        for (int i = 0; i < 4; i++) begin
            adr = sweep_adr[i];
            #1;
            check("sweep_space", 64'(space), 64'(sweep_sp[i]));
            check("sweep_mem_en", 64'(mem_en), 64'(sweep_en[i]));
        end

        // player register write/read
        bus_wr(16'hC004, 16'h1234);
        bus_rd(16'hC004);
        check("p0_read", 64'(readdata), 64'h1234);
        check("p0_out", 64'(p_regs[15:0]), 64'h1234);
        tick();
        check("rv_pulse", 64'(readvalid), 64'h0);

        // arm and capture lowest buzzer
        bus_wr(16'hC003, 16'h0001);
        player_code  = {4'h9, 4'h0, 4'h5, 4'h0};
        player_valid = 4'b1010;
        tick();
        player_valid = 4'h0;
        bus_rd(16'hC001);
        check("first", 64'(readdata), 64'h0051);
        bus_rd(16'hC000);
        check("status_flags", 64'(readdata[3:0]), 64'hA);
        check("status_locked", 64'(readdata[15]), 64'h1);

        // late buzz while locked only sets flags
        player_valid = 4'b0001;
        tick();
        player_valid = 4'h0;
        bus_rd(16'hC001);
        check("first_keep", 64'(readdata[2:0]), 64'h1);
        bus_rd(16'hC000);
        check("flags_late", 64'(readdata[3:0]), 64'hB);

        // STATUS clear beats a same-cycle buzz
        player_valid = 4'b0100;
        bus_wr(16'hC000, 16'($urandom));
        player_valid = 4'h0;
        bus_rd(16'hC000);
        check("status_clear", 64'(readdata), 64'h0);

        // arm swallows a same-cycle buzz
        player_valid = 4'b0010;
        bus_wr(16'hC003, 16'h0001);
        player_valid = 4'h0;
        bus_rd(16'hC000);
        check("arm_nocapture", 64'(readdata), 64'h1000);

        // buzz player 2 then clear (irq path when enabled)
        player_code  = 16'($urandom);
        player_valid = 4'b0100;
        tick();
        player_valid = 4'h0;
        bus_rd(16'hC001);
        check("first_p2", 64'(readdata[2:0]), 64'h2);
        bus_wr(16'hC000, 16'h0000);

        // randomized traffic
        for (int n = 0; n < 300; n++) begin
            int k;
            k = $urandom_range(0, 11);
            if (k < 9)       adr = 16'hC000 + 16'(k);
            else if (k == 9) adr = 16'h9FFF;
            else if (k == 10) adr = 16'hA000;
            else             adr = 16'($urandom_range(0, 16'h9FFF));
            writedata    = 16'($urandom);
            memwrite     = ($urandom_range(0, 3) == 0);
            memread      = 1'($urandom_range(0, 1));
            player_valid = ($urandom_range(0, 3) == 0) ? 4'($urandom) : 4'h0;
            player_code  = 16'($urandom);
            tick();
        end
        memwrite = 1'b0; memread = 1'b0; player_valid = 4'h0;

        // asynchronous reset mid-round
        bus_wr(16'hC003, 16'h0001);
        player_valid = 4'b0001;
        tick();
        player_valid = 4'h0;
        bus_wr(16'hC005, 16'hBEEF);
        bus_rd(16'hC005);
        #2;
        rst = 1'b0;
        #1;
        check("arst_readdata", 64'(readdata), 64'h0);
        check("arst_readvalid", 64'(readvalid), 64'h0);
        check("arst_p_regs", p_regs, 64'h0);
        check("arst_rand", 64'(rand_val), 64'hACE1);
`ifdef IO_BUS_IRQ_EN
        check("arst_irq", 64'(irq), 64'h0);
`endif
        model_reset();
        @(negedge clk);
        rst = 1'b1;
        bus_rd(16'hC000);
        check("arst_status", 64'(readdata), 64'h0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
